// File: rtl/dht11_multi_disp.sv
// Multi-channel DHT11 display controller: latches per-channel readings, scrolls humidity/temperature
// views over a shared seg_led display, and blanks channels that stop reporting. Macro: DHT_AUTO_SCROLL_EN.
module dht11_multi_disp #(
  parameter int CH_NUM        = 2,
  parameter int SCROLL_CYCLES = 150_000_000,
  parameter int STALE_CYCLES  = 250_000_000,
  parameter int CH_W          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [32*CH_NUM-1:0]  ch_data,
  input  logic [CH_NUM-1:0]     ch_valid,
  input  logic                  key_flag,
  input  logic                  key_value,
  output logic [19:0]           data,
  output logic [5:0]            point,
  output logic                  en,
  output logic                  sign,
  output logic [CH_W-1:0]       ch_sel,
  output logic                  show_temp,
  output logic                  stale
);

  localparam int                V_W        = CH_W + 1;
  localparam logic [V_W-1:0]    V_LAST     = V_W'(2 * CH_NUM - 1);
  localparam int                ST_W       = $clog2(STALE_CYCLES + 1);
  localparam logic [ST_W-1:0]   STALE_MAX  = ST_W'(STALE_CYCLES);

  logic [31:0]     snap_q [CH_NUM];
  logic [31:0]     snap_d [CH_NUM];
  logic [ST_W-1:0] cnt_q  [CH_NUM];
  logic [ST_W-1:0] cnt_d  [CH_NUM];
  logic [CH_NUM-1:0] seen_q, seen_d;
  logic [CH_NUM-1:0] ch_stale_s;
  logic [V_W-1:0]  v_q, v_d;
  logic            press_s;

  logic [19:0] data_q, data_d;
  logic [5:0]  point_q, point_d;
  logic        en_q, en_d;
  logic        sign_q, sign_d;
  logic        stale_q, stale_d;

  function automatic logic [V_W-1:0] next_view(input logic [V_W-1:0] v);
    if (v == V_LAST) begin
      next_view = {V_W{1'b0}};
    end else begin
      next_view = v + V_W'(1);
    end
  endfunction

  // Decimal digit is clamped to 9 so the result never exceeds 255*10+9.
  function automatic logic [19:0] reading_value(input logic [7:0] int_b, input logic [6:0] dec_b);
    logic [3:0] dig;
    if (dec_b > 7'd9) begin
      dig = 4'd9;
    end else begin
      dig = dec_b[3:0];
    end
    reading_value = ({12'd0, int_b} * 20'd10) + {16'd0, dig};
  endfunction

  assign press_s = key_flag && !key_value;

  // Per-channel snapshot, seen flag and saturating stale counter; a strobe beats saturation.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      snap_d[k]     = snap_q[k];
      seen_d[k]     = seen_q[k];
      cnt_d[k]      = cnt_q[k];
      ch_stale_s[k] = 1'b0;
      if (ch_valid[k]) begin
        snap_d[k] = ch_data[32*k +: 32];
        seen_d[k] = 1'b1;
        cnt_d[k]  = {ST_W{1'b0}};
      end else if (cnt_q[k] != STALE_MAX) begin
        cnt_d[k] = cnt_q[k] + ST_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
      if (ch_valid[k]) begin
        ch_stale_s[k] = 1'b0;
      end else begin
        ch_stale_s[k] = !seen_q[k] || (cnt_q[k] == STALE_MAX);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        snap_q[k] <= 32'd0;
        cnt_q[k]  <= {ST_W{1'b0}};
      end
      seen_q <= {CH_NUM{1'b0}};
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        snap_q[k] <= snap_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      seen_q <= seen_d;
    end
  end

`ifdef DHT_AUTO_SCROLL_EN
  typedef enum logic [0:0] {MODE_AUTO, MODE_MANUAL} mode_t;

  localparam int              SC_W        = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam int              ID_W        = $clog2(4 * SCROLL_CYCLES);
  localparam logic [SC_W-1:0] SCROLL_LAST = SC_W'(SCROLL_CYCLES - 1);
  localparam logic [ID_W-1:0] IDLE_LAST   = ID_W'(4 * SCROLL_CYCLES - 1);

  mode_t           mode_q, mode_d;
  logic [SC_W-1:0] scroll_q, scroll_d;
  logic [ID_W-1:0] idle_q, idle_d;

  // Mode FSM next state; a press in AUTO takes priority over scroll expiry.
  always_comb begin
    mode_d   = mode_q;
    scroll_d = scroll_q;
    idle_d   = idle_q;
    v_d      = v_q;
    case (mode_q)
      MODE_AUTO: begin
        if (press_s) begin
          mode_d   = MODE_MANUAL;
          scroll_d = {SC_W{1'b0}};
          idle_d   = {ID_W{1'b0}};
        end else if (scroll_q == SCROLL_LAST) begin
          v_d      = next_view(v_q);
          scroll_d = {SC_W{1'b0}};
        end else begin
          scroll_d = scroll_q + SC_W'(1);
        end
      end
      MODE_MANUAL: begin
        if (press_s) begin
          v_d    = next_view(v_q);
          idle_d = {ID_W{1'b0}};
        end else if (idle_q == IDLE_LAST) begin
          mode_d   = MODE_AUTO;
          scroll_d = {SC_W{1'b0}};
          idle_d   = {ID_W{1'b0}};
        end else begin
          idle_d = idle_q + ID_W'(1);
        end
      end
      default: begin
        mode_d   = MODE_AUTO;
        scroll_d = {SC_W{1'b0}};
        idle_d   = {ID_W{1'b0}};
      end
    endcase
  end

  // Mode and timer registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q   <= MODE_AUTO;
      scroll_q <= {SC_W{1'b0}};
      idle_q   <= {ID_W{1'b0}};
    end else begin
      mode_q   <= mode_d;
      scroll_q <= scroll_d;
      idle_q   <= idle_d;
    end
  end
`else
  // Permanently manual: every press steps the view.
  always_comb begin
    v_d = v_q;
    if (press_s) begin
      v_d = next_view(v_q);
    end else begin
      v_d = v_q;
    end
  end
`endif

  // Display bundle built from next-cycle view and snapshot so updates land one edge after the event.
  always_comb begin
    logic [CH_W-1:0] shown_s;
    logic [31:0]     word_s;
    logic [7:0]      int_s;
    logic [7:0]      dec_s;
    logic            temp_s;
    shown_s = v_d[V_W-1:1];
    temp_s  = v_d[0];
    word_s  = snap_d[shown_s];
    if (temp_s) begin
      int_s = word_s[15:8];
      dec_s = word_s[7:0];
    end else begin
      int_s = word_s[31:24];
      dec_s = word_s[23:16];
    end
    data_d  = 20'd0;
    point_d = 6'b000000;
    en_d    = 1'b0;
    sign_d  = 1'b0;
    stale_d = 1'b1;
    if (ch_stale_s[shown_s]) begin
      data_d  = 20'd0;
      point_d = 6'b000000;
      en_d    = 1'b0;
      sign_d  = 1'b0;
      stale_d = 1'b1;
    end else begin
      data_d  = reading_value(int_s, dec_s[6:0]);
      point_d = 6'b000010;
      en_d    = 1'b1;
      sign_d  = temp_s & dec_s[7];
      stale_d = 1'b0;
    end
  end

  // View index and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      v_q     <= {V_W{1'b0}};
      data_q  <= 20'd0;
      point_q <= 6'b000000;
      en_q    <= 1'b0;
      sign_q  <= 1'b0;
      stale_q <= 1'b1;
    end else begin
      v_q     <= v_d;
      data_q  <= data_d;
      point_q <= point_d;
      en_q    <= en_d;
      sign_q  <= sign_d;
      stale_q <= stale_d;
    end
  end

  assign data      = data_q;
  assign point     = point_q;
  assign en        = en_q;
  assign sign      = sign_q;
  assign stale     = stale_q;
  assign ch_sel    = v_q[V_W-1:1];
  assign show_temp = v_q[0];

endmodule
